// File: rtl/noc_pkg.sv
// Constants and flit-type codes shared by the input queues, route computation and the allocators.
package noc_pkg;

  localparam int FLIT_SIZE  = 82;
  localparam int HEADER_LEN = 3;
  localparam int IN_Q_SIZE  = 5;
  localparam int CNT_W      = 3;

  typedef enum logic [HEADER_LEN-1:0] {
    FLIT_HEAD   = 3'b000,
    FLIT_BODY   = 3'b001,
    FLIT_TAIL   = 3'b010,
    FLIT_SINGLE = 3'b011,
    FLIT_CREDIT = 3'b100
  } flit_type_e;

  typedef enum logic [2:0] {
    DIR_LOCAL = 3'd0,
    DIR_NORTH = 3'd1,
    DIR_EAST  = 3'd2,
    DIR_SOUTH = 3'd3,
    DIR_WEST  = 3'd4
  } dir_e;

  // Write-side packet framing: are we between a HEAD and its TAIL?
  typedef enum logic {
    FRM_IDLE   = 1'b0,
    FRM_IN_PKT = 1'b1
  } frame_state_e;

  // Codes above SINGLE (other than CREDIT) carry no meaning and are dropped.
  function automatic logic is_data_type(input logic [HEADER_LEN-1:0] t);
    return (t == FLIT_HEAD) || (t == FLIT_BODY) || (t == FLIT_TAIL) || (t == FLIT_SINGLE);
  endfunction

endpackage

// File: rtl/input_queue_if.sv
// Link-side and RC-side signals of one input queue; master drives flits in, slave is the queue.
interface input_queue_if
  import noc_pkg::*;
#(
  parameter int FLIT_SIZE = noc_pkg::FLIT_SIZE,
  parameter int CNT_W     = noc_pkg::CNT_W
);

  logic                 in_valid;
  logic [FLIT_SIZE-1:0] in_flit;
  logic                 stall;
  logic [FLIT_SIZE-1:0] flit_out;
  logic                 out_valid;
  logic                 credit_out;
  logic                 credit_rcv;
  logic [CNT_W-1:0]     occupancy;
  logic                 overflow_err;
  logic                 framing_err;

  modport master (
    output in_valid, in_flit, stall,
    input  flit_out, out_valid, credit_out, credit_rcv, occupancy, overflow_err, framing_err
  );

  modport slave (
    input  in_valid, in_flit, stall,
    output flit_out, out_valid, credit_out, credit_rcv, occupancy, overflow_err, framing_err
  );

endinterface

// File: rtl/flit_fifo_mem.sv
// Flit storage for one input queue: DEPTH x WIDTH registers, one synchronous write port, async read.
module flit_fifo_mem #(
  parameter int DEPTH  = 5,
  parameter int WIDTH  = 82,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; validity is tracked by occupancy, so stale contents are never consumed.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/input_queue.sv
// Per-port input buffer ahead of route computation: FWFT queue, credit return, CREDIT stripping and
// write-side packet framing check.
module input_queue #(
  parameter int FLIT_SIZE  = noc_pkg::FLIT_SIZE,
  parameter int HEADER_LEN = noc_pkg::HEADER_LEN,
  parameter int IN_Q_SIZE  = noc_pkg::IN_Q_SIZE,
  parameter int CNT_W      = noc_pkg::CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  input_queue_if.slave  bus
);

  import noc_pkg::*;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IN_Q_SIZE - 1);
  localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(IN_Q_SIZE);

  logic [CNT_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      occ;
  logic                  credit_out_q;
  logic                  credit_rcv_q;
  logic                  overflow_q;
  logic                  framing_q;
  frame_state_e          frm_state;

  logic [HEADER_LEN-1:0] ftype;
  logic                  is_credit;
  logic                  is_legal;
  logic                  data_flit;
  logic                  full;
  logic                  push;
  logic                  pop;

  // Depth need not be a power of two, so pointers wrap by comparison.
  function automatic logic [CNT_W-1:0] ptr_inc(input logic [CNT_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  assign ftype     = bus.in_flit[FLIT_SIZE-1 -: HEADER_LEN];
  assign is_credit = (ftype == FLIT_CREDIT);
  assign is_legal  = is_data_type(ftype);
  assign data_flit = bus.in_valid && !is_credit;
  assign full      = (occ == DEPTH);
  assign pop       = bus.out_valid && !bus.stall;
  // A full queue still accepts a flit when the head leaves in the same cycle.
  assign push      = data_flit && is_legal && (!full || pop);

  flit_fifo_mem #(
    .DEPTH  (IN_Q_SIZE),
    .WIDTH  (FLIT_SIZE),
    .ADDR_W (CNT_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (bus.in_flit),
    .raddr (rd_ptr),
    .rdata (bus.flit_out)
  );

  // NOTE: every state register uses non-blocking assignment so all updates see pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      occ          <= '0;
      credit_out_q <= 1'b0;
      credit_rcv_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);

      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase

      credit_out_q <= pop;
      credit_rcv_q <= bus.in_valid && is_credit;

      if (data_flit && is_legal && full && !pop) overflow_q <= 1'b1;
    end
  end

  // Framing is judged on every non-credit flit, including ones dropped for overflow or bad type.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frm_state <= FRM_IDLE;
      framing_q <= 1'b0;
    end else if (data_flit) begin
      case (frm_state)
        FRM_IDLE: begin
          if (ftype == FLIT_HEAD)        frm_state <= FRM_IN_PKT;
          else if (ftype != FLIT_SINGLE) framing_q <= 1'b1;
        end
        FRM_IN_PKT: begin
          if (ftype == FLIT_TAIL)        frm_state <= FRM_IDLE;
          else if (ftype != FLIT_BODY)   framing_q <= 1'b1;
        end
        default: frm_state <= FRM_IDLE;
      endcase
    end
  end

  assign bus.out_valid    = (occ != '0);
  assign bus.occupancy    = occ;
  assign bus.credit_out   = credit_out_q;
  assign bus.credit_rcv   = credit_rcv_q;
  assign bus.overflow_err = overflow_q;
  assign bus.framing_err  = framing_q;

endmodule

// File: tb/tb_input_queue.sv
// Self-checking bench for input_queue: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_input_queue;
  import noc_pkg::*;

  localparam int W  = FLIT_SIZE;
  localparam int PL = FLIT_SIZE - HEADER_LEN;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   cmp_en   = 1'b0;

  input_queue_if #(.FLIT_SIZE(W), .CNT_W(CNT_W)) bus ();

  input_queue #(
    .FLIT_SIZE  (W),
    .HEADER_LEN (HEADER_LEN),
    .IN_Q_SIZE  (IN_Q_SIZE),
    .CNT_W      (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of stored flits plus the packet-open flag and sticky flags.
  logic [W-1:0] m_q[$];
  bit m_in_pkt, m_credit, m_credit_rcv, m_ovf, m_frm;

  always @(posedge clk or negedge rst) begin
    logic [2:0] t;
    bit data, legal, pop;
    if (!rst) begin
      m_q.delete();
      m_in_pkt = 0; m_credit = 0; m_credit_rcv = 0; m_ovf = 0; m_frm = 0;
    end else begin
      t     = bus.in_flit[W-1 -: 3];
      data  = bus.in_valid && (t != 3'b100);
      legal = (t <= 3'b011);
      pop   = (m_q.size() != 0) && !bus.stall;
      m_credit     = pop;
      m_credit_rcv = bus.in_valid && (t == 3'b100);
      if (data) begin
        if (!m_in_pkt) begin
          if (t == 3'b000) m_in_pkt = 1;
          else if (t != 3'b011) m_frm = 1;
        end else begin
          if (t == 3'b010) m_in_pkt = 0;
          else if (t != 3'b001) m_frm = 1;
        end
      end
      if (pop) void'(m_q.pop_front());
      if (data && legal) begin
        if (m_q.size() < IN_Q_SIZE) m_q.push_back(bus.in_flit);
        else m_ovf = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_occupancy", W'(bus.occupancy), W'(m_q.size()));
      check("m_out_valid", W'(bus.out_valid), W'(m_q.size() != 0));
      if (m_q.size() != 0) check("m_flit_out", bus.flit_out, m_q[0]);
      check("m_credit_out", W'(bus.credit_out), W'(m_credit));
      check("m_credit_rcv", W'(bus.credit_rcv), W'(m_credit_rcv));
      check("m_overflow_err", W'(bus.overflow_err), W'(m_ovf));
      check("m_framing_err", W'(bus.framing_err), W'(m_frm));
    end
  end

  // Drive one cycle of inputs, then return 2 ns after the next rising edge.
  task automatic cyc(input bit v, input logic [2:0] t, input logic [PL-1:0] p, input bit s);
    bus.in_valid = v;
    bus.in_flit  = {t, p};
    bus.stall    = s;
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n, input bit s);
    for (int i = 0; i < n; i++) cyc(1'b0, 3'b000, '0, s);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.stall    = 1'b0;
    rst = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
  endtask

  logic [W-1:0]  exp_f [5];
  logic [2:0]    t2_types [5];
  int            ncred;
  logic [PL-1:0] rp;
  logic [2:0]    rt;
  int            r;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_flit  = '0;
    bus.stall    = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst    = 1'b1;
    cmp_en = 1'b1;

    check("rst_occupancy", W'(bus.occupancy), W'(0));
    check("rst_out_valid", W'(bus.out_valid), W'(0));
    check("rst_credit_out", W'(bus.credit_out), W'(0));
    check("rst_errs", W'({bus.overflow_err, bus.framing_err}), W'(0));

    // Single flit: visible one cycle after push, credit one cycle after pop.
    cyc(1'b1, FLIT_SINGLE, PL'(79'h010203), 1'b0);
    check("t1_out_valid_c1", W'(bus.out_valid), W'(1));
    check("t1_flit", bus.flit_out, {3'b011, PL'(79'h010203)});
    check("t1_credit_c1", W'(bus.credit_out), W'(0));
    idle(1, 1'b0);
    check("t1_credit_c2", W'(bus.credit_out), W'(1));
    check("t1_occ_c2", W'(bus.occupancy), W'(0));
    idle(1, 1'b0);
    check("t1_credit_c3", W'(bus.credit_out), W'(0));

    // Fill, overflow, drain in order, then wrap.
    t2_types[0] = FLIT_HEAD; t2_types[1] = FLIT_BODY; t2_types[2] = FLIT_BODY;
    t2_types[3] = FLIT_BODY; t2_types[4] = FLIT_TAIL;
    for (int i = 0; i < 5; i++) begin
      exp_f[i] = {t2_types[i], PL'(100 + i)};
      cyc(1'b1, t2_types[i], PL'(100 + i), 1'b1);
    end
    check("t2_occ_full", W'(bus.occupancy), W'(5));
    check("t2_ovf_before", W'(bus.overflow_err), W'(0));
    cyc(1'b1, FLIT_SINGLE, PL'(999), 1'b1);
    check("t2_occ_after_drop", W'(bus.occupancy), W'(5));
    check("t2_ovf_set", W'(bus.overflow_err), W'(1));
    check("t2_head_kept", bus.flit_out, exp_f[0]);
    ncred = 0;
    for (int i = 0; i < 5; i++) begin
      check("t2_order", bus.flit_out, exp_f[i]);
      idle(1, 1'b0);
      ncred += int'(bus.credit_out);
    end
    check("t2_credits", W'(ncred), W'(5));
    check("t2_occ_empty", W'(bus.occupancy), W'(0));
    for (int i = 0; i < 3; i++) begin
      exp_f[i] = {t2_types[i == 2 ? 4 : i], PL'(200 + i)};
      cyc(1'b1, t2_types[i == 2 ? 4 : i], PL'(200 + i), 1'b1);
    end
    check("t2_wrap_occ", W'(bus.occupancy), W'(3));
    for (int i = 0; i < 3; i++) begin
      check("t2_wrap_order", bus.flit_out, exp_f[i]);
      idle(1, 1'b0);
    end
    check("t2_framing_clean", W'(bus.framing_err), W'(0));

    // Full queue with a simultaneous pop accepts the new flit.
    do_reset();
    check("t3_ovf_cleared", W'(bus.overflow_err), W'(0));
    for (int i = 0; i < 5; i++) cyc(1'b1, FLIT_SINGLE, PL'(300 + i), 1'b1);
    cyc(1'b1, FLIT_SINGLE, PL'(377), 1'b0);
    check("t3_occ", W'(bus.occupancy), W'(5));
    check("t3_ovf", W'(bus.overflow_err), W'(0));
    check("t3_credit", W'(bus.credit_out), W'(1));
    check("t3_new_head", bus.flit_out, {3'b011, PL'(301)});
    idle(7, 1'b0);

    // CREDIT flits are stripped.
    do_reset();
    cyc(1'b1, FLIT_HEAD, PL'(400), 1'b1);
    cyc(1'b1, FLIT_BODY, PL'(401), 1'b1);
    cyc(1'b1, FLIT_CREDIT, PL'(402), 1'b1);
    check("t4_credit_rcv", W'(bus.credit_rcv), W'(1));
    check("t4_occ_unchanged", W'(bus.occupancy), W'(2));
    cyc(1'b1, FLIT_BODY, PL'(403), 1'b1);
    check("t4_credit_rcv_off", W'(bus.credit_rcv), W'(0));
    cyc(1'b1, FLIT_TAIL, PL'(404), 1'b1);
    check("t4_occ", W'(bus.occupancy), W'(4));
    check("t4_framing", W'(bus.framing_err), W'(0));
    idle(6, 1'b0);

    // Framing errors.
    do_reset();
    cyc(1'b1, FLIT_BODY, PL'(500), 1'b1);
    check("t5_body_idle_err", W'(bus.framing_err), W'(1));
    check("t5_body_queued", W'(bus.occupancy), W'(1));
    do_reset();
    check("t5_err_cleared", W'(bus.framing_err), W'(0));
    cyc(1'b1, FLIT_HEAD, PL'(510), 1'b1);
    check("t5_head_ok", W'(bus.framing_err), W'(0));
    cyc(1'b1, FLIT_HEAD, PL'(511), 1'b1);
    check("t5_head_head_err", W'(bus.framing_err), W'(1));
    check("t5_head_head_occ", W'(bus.occupancy), W'(2));
    do_reset();
    cyc(1'b1, 3'b111, PL'(520), 1'b1);
    check("t5_illegal_err", W'(bus.framing_err), W'(1));
    check("t5_illegal_dropped", W'(bus.occupancy), W'(0));

    // Asynchronous reset mid-packet.
    do_reset();
    cyc(1'b1, FLIT_HEAD, PL'(600), 1'b1);
    cyc(1'b1, FLIT_BODY, PL'(601), 1'b1);
    cyc(1'b1, FLIT_BODY, PL'(602), 1'b1);
    check("t6_occ_before", W'(bus.occupancy), W'(3));
    bus.in_valid = 1'b0;
    bus.stall    = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("t6_valid_async", W'(bus.out_valid), W'(0));
    check("t6_occ_async", W'(bus.occupancy), W'(0));
    @(posedge clk); #2;
    check("t6_credit_in_rst", W'(bus.credit_out), W'(0));
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1, 1'b0);
      check("t6_no_credit", W'(bus.credit_out), W'(0));
    end
    cyc(1'b1, FLIT_TAIL, PL'(610), 1'b1);
    check("t6_fsm_idle", W'(bus.framing_err), W'(1));

    // Randomized traffic under varying back-pressure; the model checks every cycle.
    for (int ph = 0; ph < 4; ph++) begin
      do_reset();
      for (int n = 0; n < 600; n++) begin
        r  = $urandom_range(99);
        rp = PL'({$urandom(), $urandom(), $urandom()});
        if (r < 8)       rt = FLIT_CREDIT;
        else if (r < 11) rt = 3'(5 + $urandom_range(2));
        else             rt = 3'($urandom_range(3));
        cyc($urandom_range(99) < 70, rt, rp, $urandom_range(99) < 20 * ph + 10);
      end
      idle(8, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
